// File: rtl/serial_adder_if.sv
// ----------------------------------------------------------------------------
// serial_adder_if
// Request/result bundle for the bit-serial adder/subtractor.
//   start  : request, sampled only while busy=0
//   sub    : 0 = a + b + cin, 1 = a - b (sampled with start)
//   cin    : carry-in for add, ignored for subtract (sampled with start)
//   a, b   : operands (sampled with start)
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when sum/cout/ovf have just been updated
//   sum    : result, held until the next completion
//   cout   : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf    : two's-complement overflow
// master = requester side, slave = the adder itself.
// ----------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder/subtractor: operands are captured on an accepted start,
// then one full-adder step per clock runs LSB first through a single carry
// flip-flop. After WIDTH steps the result, carry-out and signed overflow are
// registered and done pulses for one cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : serial_adder_if.slave (start/sub/cin/a/b in, busy/done/sum/cout/ovf out)
// Parameter WIDTH: operand/result width, 1..32.
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    // Counter must be at least one bit wide so WIDTH=1 still elaborates.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;      // operand A shift register
    logic [WIDTH-1:0] b_q;      // operand B (inverted for subtract) shift register
    logic             c_q;      // running carry
    logic [CNT_W-1:0] cnt_q;    // index of the bit processed on the next edge
    logic [WIDTH-1:0] res_q;    // partial result, filled from the MSB end
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             s_d;      // sum bit of the current step
    logic             c_d;      // carry out of the current step
    logic [WIDTH-1:0] res_d;    // result register after shifting s_d in

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        s_d   = a_q[0] ^ b_q[0] ^ c_q;
        c_d   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        res_d = res_q >> 1;
        res_d[WIDTH-1] = s_d;
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        // Subtract is a + ~b + 1: invert B and preset carry.
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        c_q     <= bus.sub | bus.cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // c_q is still the carry into the MSB at this point.
                        sum_q   <= res_d;
                        cout_q  <= c_d;
                        ovf_q   <= c_q ^ c_d;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder: an 8-bit instance for the main
// arithmetic/timing scenarios and a 1-bit instance for the full-adder case.
// Expected results come from integer arithmetic on the operands.
// ----------------------------------------------------------------------------
module tb_serial_adder;

    logic clk;
    logic rst;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, unsigned for sum/cout, signed for ovf.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic sub, input logic cin);
        int ua, ub, sa, sb, ur, sr;
        logic [7:0] s;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
            co = (ur > 255);
        end
        s  = ur[7:0];
        ov = (sr > 127) || (sr < -128);
        return {ov, co, s};
    endfunction

    // Drive one request on the 8-bit instance and observe it to completion.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic cin, input bit noise, output int lat,
                         output int busy_n, output bit held, output logic [9:0] got);
        logic [9:0] prev;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.cin = cin;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        prev   = {bus8.ovf, bus8.cout, bus8.sum};
        lat    = 0;
        busy_n = 0;
        held   = 1'b1;
        while (bus8.done !== 1'b1 && lat < 64) begin
            if (bus8.busy === 1'b1) busy_n++;
            if ({bus8.ovf, bus8.cout, bus8.sum} !== prev) held = 1'b0;
            if (noise) begin
                bus8.start = 1'($urandom_range(0, 1));
                bus8.a = 8'($urandom); bus8.b = 8'($urandom);
                bus8.sub = 1'($urandom); bus8.cin = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        bus8.start = 1'b0;
        got = {bus8.ovf, bus8.cout, bus8.sum};
    endtask

    task automatic test_reset();
        n_vec++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 12'h000 ||
            {bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovf} !== 5'b0) begin
            n_err++;
            $display("FAIL reset: w8 busy/done/sum/cout/ovf=%b/%b/%h/%b/%b w1 sum=%b, required all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf, bus1.sum);
        end
    endtask

    task automatic test_directed();
        logic [7:0] va [5] = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h80};
        logic [7:0] vb [5] = '{8'h33, 8'h01, 8'h00, 8'h20, 8'h01};
        logic       vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [9:0] req [5] = '{{1'b1, 1'b0, 8'h8D}, {1'b0, 1'b1, 8'h00},
                                {1'b1, 1'b0, 8'h80}, {1'b0, 1'b0, 8'hF0},
                                {1'b1, 1'b1, 8'h7F}};
        int lat, busy_n;
        bit held;
        logic [9:0] got;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vs[i], vc[i], 1'b0, lat, busy_n, held, got);
            n_vec++;
            if (got !== req[i] || lat != 8 || busy_n != 8) begin
                n_err++;
                $display("FAIL directed[%0d]: ovf,cout,sum=%h lat=%0d busy=%0d, required %h lat=8 busy=8",
                         i, got, lat, busy_n, req[i]);
            end
            @(posedge clk); #1;
            n_vec++;
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || {bus8.ovf, bus8.cout, bus8.sum} !== req[i]) begin
                n_err++;
                $display("FAIL done_fall[%0d]: done=%b busy=%b result=%h, required done=0 busy=0 result=%h",
                         i, bus8.done, bus8.busy, {bus8.ovf, bus8.cout, bus8.sum}, req[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, busy_n;
        bit held;
        logic [9:0] got, exp;
        logic [7:0] a, b;
        logic sub, cin;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            exp = model8(a, b, sub, cin);
            do_op(a, b, sub, cin, 1'b1, lat, busy_n, held, got);
            n_vec++;
            if (got !== exp || lat != 8 || !held) begin
                n_err++;
                $display("FAIL random[%0d] %h%s%h cin=%b: result=%h lat=%0d held=%0d, required %h lat=8 held=1",
                         i, a, sub ? "-" : "+", b, cin, got, lat, held, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa [4], ob [4];
        logic       os [4], oc [4];
        logic [9:0] exp, prev;
        int lat;
        bit held;
        for (int k = 0; k < 4; k++) begin
            oa[k] = 8'($urandom); ob[k] = 8'($urandom);
            os[k] = 1'($urandom); oc[k] = 1'($urandom);
        end
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = oa[0]; bus8.b = ob[0]; bus8.sub = os[0]; bus8.cin = oc[0];
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            exp  = model8(oa[k], ob[k], os[k], oc[k]);
            prev = {bus8.ovf, bus8.cout, bus8.sum};
            lat  = 0;
            held = 1'b1;
            while (bus8.done !== 1'b1 && lat < 64) begin
                if ({bus8.ovf, bus8.cout, bus8.sum} !== prev) held = 1'b0;
                bus8.a = 8'($urandom); bus8.b = 8'($urandom);
                bus8.sub = 1'($urandom); bus8.cin = 1'($urandom);
                @(posedge clk); #1;
                lat++;
            end
            n_vec++;
            if ({bus8.ovf, bus8.cout, bus8.sum} !== exp || lat != 8 || !held) begin
                n_err++;
                $display("FAIL b2b[%0d]: result=%h lat=%0d held=%0d, required %h lat=8 held=1",
                         k, {bus8.ovf, bus8.cout, bus8.sum}, lat, held, exp);
            end
            if (k < 3) begin
                bus8.a = oa[k+1]; bus8.b = ob[k+1]; bus8.sub = os[k+1]; bus8.cin = oc[k+1];
            end else begin
                bus8.start = 1'b0;
            end
            @(posedge clk); #1;
            n_vec++;
            if (bus8.busy !== (k < 3) || bus8.done !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_accept[%0d]: busy=%b done=%b, required busy=%0d done=0",
                         k, bus8.busy, bus8.done, (k < 3));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, busy_n, seen;
        bit held;
        logic [9:0] got;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.sub = 1'b0; bus8.cin = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 12'h000) begin
            n_err++;
            $display("FAIL rst_mid_run: busy/done/sum/cout/ovf=%b/%b/%h/%b/%b, required all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL rst_no_done: %0d cycles with done/busy after abort, required 0", seen);
        end
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, lat, busy_n, held, got);
        n_vec++;
        if (got !== 10'h002 || lat != 8) begin
            n_err++;
            $display("FAIL rst_restart: result=%h lat=%0d, required 002 lat=8", got, lat);
        end
    endtask

    task automatic test_width1();
        logic [1:0] ab;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            @(negedge clk);
            bus1.start = 1'b1; bus1.a = ab[1]; bus1.b = ab[0]; bus1.sub = 1'b0; bus1.cin = 1'b0;
            @(posedge clk); #1;
            bus1.start = 1'b0;
            n_vec++;
            if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
                n_err++;
                $display("FAIL w1_accept[%0d]: busy=%b done=%b, required busy=1 done=0", i, bus1.busy, bus1.done);
            end
            @(posedge clk); #1;
            n_vec++;
            if (bus1.done !== 1'b1 || bus1.sum !== (ab[1] ^ ab[0]) || bus1.cout !== (ab[1] & ab[0])) begin
                n_err++;
                $display("FAIL w1[%0d] a=%b b=%b: done=%b sum=%b cout=%b, required done=1 sum=%b cout=%b",
                         i, ab[1], ab[0], bus1.done, bus1.sum, bus1.cout, ab[1] ^ ab[0], ab[1] & ab[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.cin = 1'b0; bus1.a = '0; bus1.b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_directed();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
